elbeth_load_align: RTL and testbench
====================================

# elbeth_load_align

Load-data alignment and extension unit between the ELBETH memory stage and the data-memory read port. It accepts one load request at a time and issues one or two word-aligned memory reads. A load that crosses a word boundary needs two reads, and those are merged. The unit then shifts the addressed bytes to bit 0, zero- or sign-extends them to full width, and presents the result to writeback over a valid/ready handshake. It supersedes the combinational zero/sign extender by adding byte-offset handling, misaligned-access support or faulting, parametrised width and request/response sequencing.

## Interface
- DATA_WIDTH, 32: memory word and result width. Legal values are 32 or 64. BYTES = DATA_WIDTH/8.
- ALLOW_MISALIGNED, 1:
  - 1: boundary-crossing loads are split into two reads.
  - 0: any load not naturally aligned faults.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  32  byte address.
- req_size  in  2  access size: 0 byte, 1 halfword, 2 word, 3 doubleword (doubleword legal only when DATA_WIDTH=64).
- req_signed  in  1  1 = sign-extend, 0 = zero-extend.
- mem_rd_valid  out  1  read address valid.
- mem_rd_ready  in  1  memory accepts the read.
- mem_rd_addr  out  32  word-aligned read address (low log2(BYTES) bits zero).
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  DATA_WIDTH  read data, little-endian.
- load_valid  out  1  result valid.
- load_ready  in  1  writeback accepts the result.
- load_data  out  DATA_WIDTH  aligned, extended result.
- load_fault  out  1  misaligned or illegal-size load; qualified by load_valid.

## Operation
- Definitions:
  - off = req_addr mod BYTES.
  - nb = 1 << req_size.
  - cross = (off + nb > BYTES).
- Capture: on req_valid && req_ready, the unit registers addr, size, signed, off and cross.
- FSM states: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, RESP.
- IDLE:
  - Fault accept goes to RESP with fault=1 and data=0. No memory traffic occurs. A fault accept is:
    - an illegal size (req_size=3 with DATA_WIDTH=32), or
    - ALLOW_MISALIGNED=0 with off not a multiple of nb.
  - Any other accept goes to REQ_LO.
- REQ_LO:
  - mem_rd_valid=1, mem_rd_addr = addr with the low bits cleared.
  - Advances to WAIT_LO on mem_rd_ready.
- WAIT_LO: on mem_rsp_valid, captures lo = mem_rsp_data.
  - Goes to REQ_HI if cross, otherwise to RESP.
- REQ_HI: mem_rd_addr = aligned addr + BYTES, wrapping modulo 2^32. Advances to WAIT_HI on mem_rd_ready.
- WAIT_HI: on mem_rsp_valid, captures hi and goes to RESP.
- Merge:
  - raw = ({hi, lo} >> (8*off)) truncated to DATA_WIDTH.
  - hi = 0 when not crossing.
- Extend: the low 8*nb bits of raw are kept; the upper bits are filled with raw[8*nb-1] if signed, else 0.
  - Full-width (nb = BYTES) loads pass raw unchanged.
  - req_signed has no effect on full-width loads.
- RESP: load_valid=1, with load_data and load_fault registered. The state holds until load_ready, then goes to IDLE.
- mem_rsp_valid outside WAIT_LO and WAIT_HI is ignored.
- mem_rd_addr, mem_rd_valid, req_ready, load_valid and load_fault are decoded from registered state only; there is no combinational path from any input.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - mem_rd_valid=0, load_valid=0, load_fault=0, load_data=0, mem_rd_addr=0, and all captured fields are cleared.
  - After reset deassertion, req_ready=1.
  - A response from an aborted read that arrives after reset is dropped (IDLE ignores it).

## Timing
- One request is in flight; no new request is accepted until the result is consumed.
- Aligned load, zero-wait memory (read accepted the cycle it is issued, response one cycle later):
  - accept at edge 0;
  - mem_rd_valid during cycle 1;
  - response during cycle 2;
  - load_valid during cycle 3.
- Crossing load, zero-wait memory: load_valid during cycle 5.
- Fault: load_valid during cycle 1.
- Back-to-back loads: after the load_ready handshake at edge N, req_ready is high during cycle N+1, so the request-to-request throughput is 1 per (latency + 1) cycles.
- Holding stability:
  - mem_rd_addr is stable while mem_rd_valid && !mem_rd_ready.
  - load_data and load_fault are stable while load_valid && !load_ready.

## Test plan
- Word aligned, DATA_WIDTH=32, addr 0x100, rsp 0x800000FF, signed=1 -> one read at 0x100; load_data=0x800000FF, fault=0, load_valid in cycle 3.
- Byte at addr 0x103, rsp 0x80123456:
  - signed -> 0xFFFFFF80;
  - unsigned -> 0x00000080.
- Halfword at 0x102, rsp 0xF00D1234:
  - signed -> 0xFFFFF00D;
  - unsigned -> 0x0000F00D.
- Crossing word at 0x103, ALLOW_MISALIGNED=1, rsp lo 0xAABBCCDD (read at 0x100), hi 0x11223344 (read at 0x104) -> load_data=0x223344AA.
  - Repeat with addr 0xFFFFFFFF -> second read at 0x00000000 (address wraps).
- Same crossing request with ALLOW_MISALIGNED=0 -> no mem_rd_valid; load_valid in cycle 1 with fault=1, data=0.
  - Repeat with req_size=3 at DATA_WIDTH=32 -> same fault response.
- Stalls and reset:
  - mem_rd_ready low 4 cycles -> mem_rd_addr stable throughout.
  - load_ready low 3 cycles -> load_data stable throughout.
  - Assert rst in WAIT_LO, then deliver the stale mem_rsp_valid -> all outputs 0, req_ready=1, and the next load returns correct data.

Source files
------------

// File: rtl/elbeth_load_align.sv
// Load alignment and extension unit: issues one or two word-aligned reads per load,
// merges boundary-crossing data, shifts the addressed bytes to bit 0 and extends them.
module elbeth_load_align #(
  parameter int DATA_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  output logic                  mem_rd_valid,
  input  logic                  mem_rd_ready,
  output logic [31:0]           mem_rd_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  load_valid,
  input  logic                  load_ready,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_fault
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int IW    = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LO  = 3'd1,
    WAIT_LO = 3'd2,
    REQ_HI  = 3'd3,
    WAIT_HI = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t          state;
  logic [1:0]      size_r;
  logic            signed_r;
  logic [OFFW-1:0] off_r;
  logic            cross_r;
  logic [DATA_WIDTH-1:0] lo_r;

  logic [OFFW-1:0] off_s;
  logic [3:0]      nb_s;
  logic            cross_s;
  logic            fault_s;

  // Shift {hi,lo} down by the byte offset, then zero/sign-extend above the access width.
  function automatic logic [DATA_WIDTH-1:0] align_extend(
    input logic [DATA_WIDTH-1:0] lo,
    input logic [DATA_WIDTH-1:0] hi,
    input logic [OFFW-1:0]       off,
    input logic [1:0]            size,
    input logic                  sgn
  );
    logic [2*DATA_WIDTH-1:0] cat;
    logic [DATA_WIDTH-1:0]   raw;
    logic [DATA_WIDTH-1:0]   res;
    logic [IW-1:0]           top;
    int                      nbits;
    logic                    fill;
    cat   = {hi, lo} >> {off, 3'b000};
    raw   = cat[DATA_WIDTH-1:0];
    nbits = 32'd8 << size;
    top   = IW'(nbits - 1);
    if (nbits < DATA_WIDTH) begin
      fill = sgn & raw[top];
    end else begin
      fill = 1'b0;
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < nbits) begin
        res[i] = raw[i];
      end else begin
        res[i] = fill;
      end
    end
    return res;
  endfunction

  // Decode the incoming request: byte offset, size in bytes, boundary crossing, fault.
  always_comb begin
    off_s   = req_addr[OFFW-1:0];
    nb_s    = 4'd1 << req_size;
    cross_s = (5'(off_s) + 5'(nb_s)) > 5'(BYTES);
    fault_s = ((req_size == 2'd3) && (DATA_WIDTH == 32)) ||
              (!ALLOW_MISALIGNED && ((4'(off_s) & (nb_s - 4'd1)) != 4'd0));
  end

  assign req_ready    = (state == IDLE);
  assign mem_rd_valid = (state == REQ_LO) || (state == REQ_HI);
  assign load_valid   = (state == RESP);

  // Request sequencing FSM with registered read address and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      size_r      <= 2'd0;
      signed_r    <= 1'b0;
      off_r       <= {OFFW{1'b0}};
      cross_r     <= 1'b0;
      lo_r        <= {DATA_WIDTH{1'b0}};
      mem_rd_addr <= 32'd0;
      load_data   <= {DATA_WIDTH{1'b0}};
      load_fault  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_r      <= req_size;
            signed_r    <= req_signed;
            off_r       <= off_s;
            cross_r     <= cross_s;
            mem_rd_addr <= {req_addr[31:OFFW], {OFFW{1'b0}}};
            if (fault_s) begin
              load_fault <= 1'b1;
              load_data  <= {DATA_WIDTH{1'b0}};
              state      <= RESP;
            end else begin
              load_fault <= 1'b0;
              state      <= REQ_LO;
            end
          end
        end
        REQ_LO: begin
          if (mem_rd_ready) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (mem_rsp_valid) begin
            lo_r <= mem_rsp_data;
            if (cross_r) begin
              mem_rd_addr <= mem_rd_addr + 32'(BYTES);
              state       <= REQ_HI;
            end else begin
              load_data <= align_extend(mem_rsp_data, {DATA_WIDTH{1'b0}}, off_r, size_r, signed_r);
              state     <= RESP;
            end
          end
        end
        REQ_HI: begin
          if (mem_rd_ready) state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (mem_rsp_valid) begin
            load_data <= align_extend(lo_r, mem_rsp_data, off_r, size_r, signed_r);
            state     <= RESP;
          end
        end
        RESP: begin
          if (load_ready) begin
            load_fault <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elbeth_load_align.sv
// Directed bench for elbeth_load_align: one misaligned-capable instance and one
// strict-alignment instance sharing clock, reset and memory/writeback stimulus.
module tb_elbeth_load_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_a, req_valid_b;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        mem_rd_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        load_ready;

  logic        req_ready_a, mem_rd_valid_a, load_valid_a, load_fault_a;
  logic [31:0] mem_rd_addr_a, load_data_a;
  logic        req_ready_b, mem_rd_valid_b, load_valid_b, load_fault_b;
  logic [31:0] mem_rd_addr_b, load_data_b;

  bit          sel_b;
  logic        o_req_ready, o_rd_valid, o_load_valid, o_load_fault;
  logic [31:0] o_rd_addr, o_load_data;

  int checks = 0;
  int errors = 0;

  int          n_rd, lv_cyc;
  logic [31:0] rd0, rd1, ld_data;
  logic        ld_fault;
  bit          addr_moved, data_moved;

  always #5 clk = ~clk;

  elbeth_load_align #(.DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed),
    .mem_rd_valid(mem_rd_valid_a), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr_a),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .load_valid(load_valid_a), .load_ready(load_ready),
    .load_data(load_data_a), .load_fault(load_fault_a)
  );

  elbeth_load_align #(.DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed),
    .mem_rd_valid(mem_rd_valid_b), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr_b),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .load_valid(load_valid_b), .load_ready(load_ready),
    .load_data(load_data_b), .load_fault(load_fault_b)
  );

  assign o_req_ready  = sel_b ? req_ready_b    : req_ready_a;
  assign o_rd_valid   = sel_b ? mem_rd_valid_b : mem_rd_valid_a;
  assign o_rd_addr    = sel_b ? mem_rd_addr_b  : mem_rd_addr_a;
  assign o_load_valid = sel_b ? load_valid_b   : load_valid_a;
  assign o_load_data  = sel_b ? load_data_b    : load_data_a;
  assign o_load_fault = sel_b ? load_fault_b   : load_fault_a;

  // Issue one load and act as a memory that answers one cycle after each accepted read.
  // Entered and left at 1 time unit after a rising edge; cycle 0 is the accept edge.
  task automatic run_load(input bit use_b, input logic [31:0] a, input logic [1:0] sz,
                          input logic sg, input logic [31:0] lo, input logic [31:0] hi,
                          input int rd_stall, input int ld_stall);
    int   cyc, rd_cnt, ld_cnt, n_rsp;
    bit   rsp_next, done;
    logic [31:0] held_addr;
    sel_b = use_b; n_rd = 0; lv_cyc = -1; rd0 = 32'hxxxxxxxx; rd1 = 32'hxxxxxxxx;
    ld_data = 32'hxxxxxxxx; ld_fault = 1'bx; addr_moved = 1'b0; data_moved = 1'b0;
    req_addr = a; req_size = sz; req_signed = sg;
    for (int w = 0; w < 20 && !o_req_ready; w++) begin
      @(posedge clk); #1;
    end
    if (use_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    cyc = 1; rd_cnt = 0; ld_cnt = 0; n_rsp = 0; rsp_next = 1'b0; done = 1'b0;
    held_addr = 32'd0;
    while (!done && cyc < 60) begin
      mem_rsp_valid = rsp_next;
      mem_rsp_data  = (n_rsp == 0) ? lo : hi;
      if (rsp_next) n_rsp++;
      rsp_next     = 1'b0;
      mem_rd_ready = 1'b0;
      load_ready   = 1'b0;
      if (o_rd_valid) begin
        if (rd_cnt == 0) begin
          held_addr = o_rd_addr;
          if (n_rd == 0) rd0 = o_rd_addr; else rd1 = o_rd_addr;
          n_rd++;
        end else if (o_rd_addr !== held_addr) begin
          addr_moved = 1'b1;
        end
        if (rd_cnt >= rd_stall) begin
          mem_rd_ready = 1'b1; rsp_next = 1'b1; rd_cnt = 0;
        end else begin
          rd_cnt++;
        end
      end
      if (o_load_valid) begin
        if (lv_cyc < 0) begin
          lv_cyc = cyc; ld_data = o_load_data; ld_fault = o_load_fault;
        end else if (o_load_data !== ld_data || o_load_fault !== ld_fault) begin
          data_moved = 1'b1;
        end
        if (ld_cnt >= ld_stall) begin
          load_ready = 1'b1; done = 1'b1;
        end else begin
          ld_cnt++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    load_ready = 1'b0; mem_rd_ready = 1'b0; mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready_a, mem_rd_valid_a, load_valid_a, load_fault_a} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl_a: got %b expected 1000",
                         {req_ready_a, mem_rd_valid_a, load_valid_a, load_fault_a});
    end
    checks++;
    if ({mem_rd_addr_a, load_data_a} !== 64'd0) begin
      errors++; $display("FAIL reset_data_a: got %h expected 0", {mem_rd_addr_a, load_data_a});
    end
    checks++;
    if ({req_ready_b, mem_rd_valid_b, load_valid_b, load_fault_b} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl_b: got %b expected 1000",
                         {req_ready_b, mem_rd_valid_b, load_valid_b, load_fault_b});
    end
  endtask

  task automatic test_aligned_word();
    run_load(1'b0, 32'h100, 2'd2, 1'b1, 32'h800000FF, 32'h0, 0, 0);
    checks++;
    if (n_rd !== 1 || rd0 !== 32'h100) begin
      errors++; $display("FAIL word_reads: got n=%0d addr=%h expected n=1 addr=00000100", n_rd, rd0);
    end
    checks++;
    if (ld_data !== 32'h800000FF || ld_fault !== 1'b0) begin
      errors++; $display("FAIL word_data: got %h/%b expected 800000ff/0", ld_data, ld_fault);
    end
    checks++;
    if (lv_cyc !== 3) begin
      errors++; $display("FAIL word_latency: got %0d expected 3", lv_cyc);
    end
  endtask

  task automatic test_byte();
    run_load(1'b0, 32'h103, 2'd0, 1'b1, 32'h80123456, 32'h0, 0, 0);
    checks++;
    if (ld_data !== 32'hFFFFFF80 || lv_cyc !== 3) begin
      errors++; $display("FAIL byte_signed: got %h cyc %0d expected ffffff80 cyc 3", ld_data, lv_cyc);
    end
    run_load(1'b0, 32'h103, 2'd0, 1'b0, 32'h80123456, 32'h0, 0, 0);
    checks++;
    if (ld_data !== 32'h00000080 || ld_fault !== 1'b0) begin
      errors++; $display("FAIL byte_unsigned: got %h/%b expected 00000080/0", ld_data, ld_fault);
    end
  endtask

  task automatic test_halfword();
    run_load(1'b0, 32'h102, 2'd1, 1'b1, 32'hF00D1234, 32'h0, 0, 0);
    checks++;
    if (ld_data !== 32'hFFFFF00D || lv_cyc !== 3) begin
      errors++; $display("FAIL half_signed: got %h cyc %0d expected fffff00d cyc 3", ld_data, lv_cyc);
    end
    run_load(1'b0, 32'h102, 2'd1, 1'b0, 32'hF00D1234, 32'h0, 0, 0);
    checks++;
    if (ld_data !== 32'h0000F00D) begin
      errors++; $display("FAIL half_unsigned: got %h expected 0000f00d", ld_data);
    end
    run_load(1'b0, 32'h101, 2'd1, 1'b0, 32'hF00D1234, 32'h0, 0, 0);
    checks++;
    if (ld_data !== 32'h00000D12 || n_rd !== 1 || rd0 !== 32'h100) begin
      errors++; $display("FAIL half_off1: got %h n=%0d addr=%h expected 00000d12 n=1 addr=00000100",
                         ld_data, n_rd, rd0);
    end
  endtask

  task automatic test_crossing();
    run_load(1'b0, 32'h103, 2'd2, 1'b0, 32'hAABBCCDD, 32'h11223344, 0, 0);
    checks++;
    if (n_rd !== 2 || rd0 !== 32'h100 || rd1 !== 32'h104) begin
      errors++; $display("FAIL cross_reads: got n=%0d %h %h expected n=2 00000100 00000104", n_rd, rd0, rd1);
    end
    checks++;
    if (ld_data !== 32'h223344AA || ld_fault !== 1'b0 || lv_cyc !== 5) begin
      errors++; $display("FAIL cross_data: got %h/%b cyc %0d expected 223344aa/0 cyc 5", ld_data, ld_fault, lv_cyc);
    end
    run_load(1'b0, 32'hFFFFFFFF, 2'd2, 1'b0, 32'hAABBCCDD, 32'h11223344, 0, 0);
    checks++;
    if (rd0 !== 32'hFFFFFFFC || rd1 !== 32'h00000000 || ld_data !== 32'h223344AA) begin
      errors++; $display("FAIL cross_wrap: got %h %h data %h expected fffffffc 00000000 data 223344aa",
                         rd0, rd1, ld_data);
    end
  endtask

  task automatic test_fault();
    run_load(1'b1, 32'h103, 2'd2, 1'b0, 32'hAABBCCDD, 32'h11223344, 0, 0);
    checks++;
    if (n_rd !== 0 || lv_cyc !== 1 || ld_fault !== 1'b1 || ld_data !== 32'h0) begin
      errors++; $display("FAIL misalign_fault: got n=%0d cyc %0d fault %b data %h expected n=0 cyc 1 fault 1 data 0",
                         n_rd, lv_cyc, ld_fault, ld_data);
    end
    run_load(1'b0, 32'h100, 2'd3, 1'b0, 32'hAABBCCDD, 32'h11223344, 0, 0);
    checks++;
    if (n_rd !== 0 || lv_cyc !== 1 || ld_fault !== 1'b1 || ld_data !== 32'h0) begin
      errors++; $display("FAIL size_fault: got n=%0d cyc %0d fault %b data %h expected n=0 cyc 1 fault 1 data 0",
                         n_rd, lv_cyc, ld_fault, ld_data);
    end
    run_load(1'b1, 32'h102, 2'd1, 1'b1, 32'hF00D1234, 32'h0, 0, 0);
    checks++;
    if (ld_data !== 32'hFFFFF00D || ld_fault !== 1'b0 || lv_cyc !== 3) begin
      errors++; $display("FAIL strict_aligned: got %h/%b cyc %0d expected fffff00d/0 cyc 3", ld_data, ld_fault, lv_cyc);
    end
  endtask

  task automatic test_stalls();
    run_load(1'b0, 32'h103, 2'd2, 1'b0, 32'hAABBCCDD, 32'h11223344, 4, 3);
    checks++;
    if (addr_moved !== 1'b0 || rd0 !== 32'h100 || rd1 !== 32'h104) begin
      errors++; $display("FAIL rd_stall_addr: got moved=%b %h %h expected moved=0 00000100 00000104",
                         addr_moved, rd0, rd1);
    end
    checks++;
    if (data_moved !== 1'b0 || ld_data !== 32'h223344AA || lv_cyc !== 13) begin
      errors++; $display("FAIL ld_stall_data: got moved=%b %h cyc %0d expected moved=0 223344aa cyc 13",
                         data_moved, ld_data, lv_cyc);
    end
  endtask

  task automatic test_back_to_back();
    run_load(1'b0, 32'h200, 2'd2, 1'b0, 32'h12345678, 32'h0, 0, 0);
    checks++;
    if (req_ready_a !== 1'b1 || load_valid_a !== 1'b0) begin
      errors++; $display("FAIL b2b_ready: got ready=%b valid=%b expected 1 0", req_ready_a, load_valid_a);
    end
    run_load(1'b0, 32'h204, 2'd0, 1'b0, 32'hCAFEBABE, 32'h0, 0, 0);
    checks++;
    if (ld_data !== 32'h000000BE || lv_cyc !== 3 || rd0 !== 32'h204) begin
      errors++; $display("FAIL b2b_second: got %h cyc %0d addr %h expected 000000be cyc 3 addr 00000204",
                         ld_data, lv_cyc, rd0);
    end
  endtask

  task automatic test_reset_mid();
    sel_b = 1'b0;
    req_addr = 32'h300; req_size = 2'd2; req_signed = 1'b0; req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0; mem_rd_ready = 1'b1;
    @(posedge clk); #1;
    mem_rd_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_rd_valid_a, load_valid_a, load_fault_a, req_ready_a} !== 4'b0001 ||
        {mem_rd_addr_a, load_data_a} !== 64'd0) begin
      errors++; $display("FAIL mid_reset: got ctrl=%b addr=%h data=%h expected ctrl=0001 addr=0 data=0",
                         {mem_rd_valid_a, load_valid_a, load_fault_a, req_ready_a}, mem_rd_addr_a, load_data_a);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (load_valid_a !== 1'b0 || req_ready_a !== 1'b1 || mem_rd_valid_a !== 1'b0) begin
      errors++; $display("FAIL stale_rsp: got valid=%b ready=%b rd=%b expected 0 1 0",
                         load_valid_a, req_ready_a, mem_rd_valid_a);
    end
    run_load(1'b0, 32'h300, 2'd2, 1'b0, 32'h0BADF00D, 32'h0, 0, 0);
    checks++;
    if (ld_data !== 32'h0BADF00D || lv_cyc !== 3 || rd0 !== 32'h300) begin
      errors++; $display("FAIL post_reset_load: got %h cyc %0d addr %h expected 0badf00d cyc 3 addr 00000300",
                         ld_data, lv_cyc, rd0);
    end
  endtask

  initial begin
    rst = 1'b1; sel_b = 1'b0;
    req_valid_a = 1'b0; req_valid_b = 1'b0; req_addr = 32'd0; req_size = 2'd0; req_signed = 1'b0;
    mem_rd_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0; load_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_aligned_word();
    test_byte();
    test_halfword();
    test_crossing();
    test_fault();
    test_stalls();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
